ctrl_scheduler: RTL and testbench

CTRL_SCHEDULER -- requirements
Module: ctrl_scheduler

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/cmd_fifo.sv | 53 +++++
 rtl/ctrl_scheduler.sv | 167 ++++++++++++++++
 tb/tb_ctrl_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared command encoding between the control sources, the scheduler and the playfield engine.
package ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    LEFT      = 3'd1,
    RIGHT     = 3'd2,
    ROTATE    = 3'd3,
    SOFT_DOWN = 3'd4,
    HARD_DROP = 3'd5,
    HOLD      = 3'd6,
    GRAVITY   = 3'd7
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } sched_state_t;

  localparam logic [2:0] MAX_LEVEL = 3'd7;

  // Only player commands are queued; NONE and GRAVITY are never accepted from a source.
  function automatic logic is_user_cmd(input ctrl_t c);
    return (c != CMD_NONE) && (c != GRAVITY);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: up to two pushes and one pop per cycle, head read combinationally.
// Caller guarantees pushes never exceed free space; a pop on an empty queue is ignored.
module cmd_fifo
  import ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_a,
  input  ctrl_t         dat_a,
  input  logic          push_b,
  input  ctrl_t         dat_b,
  input  logic          pop,
  output ctrl_t         head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  ctrl_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_b;
  logic          pop_ok;

  assign pop_ok   = pop && !empty;
  assign wr_ptr_b = wr_ptr + AW'(push_a);
  assign head     = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= dat_a;
    if (push_b) mem[wr_ptr_b] <= dat_b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/ctrl_scheduler.sv
// Merges button/UART commands and gravity ticks into one command stream for the playfield engine.
// Strobe to control is 2 cycles; ready stalls issue while the queue keeps absorbing arrivals.
module ctrl_scheduler
  import ctrl_pkg::*;
#(
  parameter  int unsigned BASE_PERIOD = 50_000_000,
  parameter  int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned QW          = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned TW          = $clog2(BASE_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          btn_valid,
  input  logic [2:0]    btn_cmd,
  input  logic          uart_valid,
  input  logic [2:0]    uart_cmd,
  input  logic [3:0]    level,
  input  logic          pause,
  input  logic          ready,
  output logic [2:0]    control,
  output logic          busy,
  output logic          overflow,
  output logic [QW-1:0] queue_count
);

  sched_state_t  state;
  sched_state_t  next_state;
  logic [2:0]    lvl;
  logic [TW-1:0] period;
  logic [TW-1:0] grav_cnt;
  logic          grav_tick;
  logic          grav_pend;
  logic          btn_ok;
  logic          uart_ok;
  logic          push_a;
  logic          push_b;
  ctrl_t         dat_a;
  ctrl_t         dat_b;
  logic          drop;
  logic          fifo_pop;
  ctrl_t         fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [QW-1:0] fifo_count;
  logic [QW-1:0] free_slots;
  logic          start;
  logic          issue_grav;
  ctrl_t         issue_cmd;
  ctrl_t         control_d;
  logic          busy_d;

  // Gravity timer
  assign lvl    = (level > 4'(MAX_LEVEL)) ? MAX_LEVEL : level[2:0];
  assign period = TW'(BASE_PERIOD) >> lvl;
  // cnt+1 >= period is cnt >= period-1 without underflow when period shifts to 0.
  assign grav_tick = ({1'b0, grav_cnt} + (TW + 1)'(1)) >= {1'b0, period};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grav_cnt <= '0;
    end else if (!pause) begin
      grav_cnt <= grav_tick ? '0 : grav_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grav_pend <= 1'b0;
    end else if (issue_grav) begin
      grav_pend <= 1'b0;
    end else if (!pause && grav_tick) begin
      grav_pend <= 1'b1;
    end
  end

  // Arrival arbitration: button always takes the first free slot.
  assign btn_ok     = btn_valid && is_user_cmd(ctrl_t'(btn_cmd));
  assign uart_ok    = uart_valid && is_user_cmd(ctrl_t'(uart_cmd));
  assign free_slots = QW'(FIFO_DEPTH) - fifo_count;

  always_comb begin
    push_a = 1'b0;
    push_b = 1'b0;
    dat_a  = ctrl_t'(btn_cmd);
    dat_b  = ctrl_t'(uart_cmd);
    drop   = 1'b0;
    if (btn_ok && uart_ok) begin
      if (free_slots >= QW'(2)) begin
        push_a = 1'b1;
        push_b = 1'b1;
      end else if (free_slots == QW'(1)) begin
        push_a = 1'b1;
        drop   = 1'b1;
      end else begin
        drop   = 1'b1;
      end
    end else if (btn_ok || uart_ok) begin
      dat_a = btn_ok ? ctrl_t'(btn_cmd) : ctrl_t'(uart_cmd);
      if (fifo_full) drop   = 1'b1;
      else           push_a = 1'b1;
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_a  (push_a),
    .dat_a   (dat_a),
    .push_b  (push_b),
    .dat_b   (dat_b),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Issue FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ready && !pause && (grav_pend || !fifo_empty)) next_state = ISSUE;
      ISSUE:   next_state = GUARD;
      GUARD:   next_state = WAIT;
      WAIT:    if (ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign start      = (state == IDLE) && (next_state == ISSUE);
  assign issue_grav = start && grav_pend;
  assign fifo_pop   = start && !grav_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   issue_cmd <= CMD_NONE;
    else if (start) issue_cmd <= grav_pend ? GRAVITY : fifo_head;
  end

  // The registered control pulse is the ISSUE cycle's command, presented one stage later.
  always_comb begin
    control_d = CMD_NONE;
    busy_d    = (next_state != IDLE);
    if (state == ISSUE) control_d = issue_cmd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      control  <= CMD_NONE;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      control  <= control_d;
      busy     <= busy_d;
      overflow <= drop;
    end
  end

  assign queue_count = fifo_count;

endmodule

// File: tb/tb_ctrl_scheduler.sv
// Directed scoreboard bench for ctrl_scheduler with BASE_PERIOD=16, FIFO_DEPTH=4.
module tb_ctrl_scheduler;

  localparam int K_NONE  = 0;
  localparam int K_LEFT  = 1;
  localparam int K_RIGHT = 2;
  localparam int K_ROT   = 3;
  localparam int K_SOFT  = 4;
  localparam int K_HOLD  = 6;
  localparam int K_GRAV  = 7;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_valid = 1'b0;
  logic [2:0] btn_cmd = 3'd0;
  logic       uart_valid = 1'b0;
  logic [2:0] uart_cmd = 3'd0;
  logic [3:0] level = 4'd0;
  logic       pause = 1'b0;
  logic       ready = 1'b1;
  logic [2:0] control;
  logic       busy;
  logic       overflow;
  logic [2:0] queue_count;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulses = 0;
  int grav = 0;
  int grav_last = 0;
  int grav_prev = 0;
  int last_ctrl = 0;
  int g0 = 0;
  int p0 = 0;
  int p1 = 0;
  int sb[$];

  ctrl_scheduler #(
    .BASE_PERIOD (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_valid   (btn_valid),
    .btn_cmd     (btn_cmd),
    .uart_valid  (uart_valid),
    .uart_cmd    (uart_cmd),
    .level       (level),
    .pause       (pause),
    .ready       (ready),
    .control     (control),
    .busy        (busy),
    .overflow    (overflow),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: sample on the falling edge and score any command pulse.
  task automatic step();
    int e;
    @(negedge clk);
    cyc++;
    if (control != 3'd0) begin
      pulses++;
      last_ctrl = int'(control);
      if (int'(control) == K_GRAV) begin
        grav++;
        grav_prev = grav_last;
        grav_last = cyc;
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_order", int'(control), e);
      end else begin
        check("sb_unexpected", int'(control), K_NONE);
      end
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(input logic bv, input int bc, input logic uv, input int uc);
    btn_valid  = bv;
    btn_cmd    = 3'(bc);
    uart_valid = uv;
    uart_cmd   = 3'(uc);
    step();
    btn_valid  = 1'b0;
    uart_valid = 1'b0;
    btn_cmd    = 3'd0;
    uart_cmd   = 3'd0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) step();
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_control", int'(control), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_count", int'(queue_count), 0);
    reset_n = 1'b1;
    step_n(2);

    // Single strobe: enqueue at N, busy at N+1, control at N+2 only
    sb.push_back(K_LEFT);
    strobe(1'b1, K_LEFT, 1'b0, K_NONE);
    check("lat_count_n", int'(queue_count), 1);
    check("lat_busy_n", int'(busy), 0);
    step();
    check("lat_busy_n1", int'(busy), 1);
    check("lat_ctl_n1", int'(control), K_NONE);
    check("lat_pop_n1", int'(queue_count), 0);
    step();
    check("lat_ctl_n2", int'(control), K_LEFT);
    ready = 1'b0;
    step();
    check("lat_ctl_n3", int'(control), K_NONE);
    check("lat_busy_guard", int'(busy), 1);
    step();
    check("lat_busy_wait", int'(busy), 1);
    ready = 1'b1;
    step();
    check("lat_busy_idle", int'(busy), 0);

    // Gravity at level 2 (period 4) and clamped level 9 (period 0, coalesced)
    level = 4'd2;
    step_n(12);
    g0 = grav;
    step_n(40);
    check("lvl2_ticks", grav - g0, 10);
    check("lvl2_gap", grav_last - grav_prev, 4);
    level = 4'd9;
    step_n(12);
    g0 = grav;
    step_n(40);
    check("lvl9_ticks", grav - g0, 10);
    check("lvl9_gap", grav_last - grav_prev, 4);
    level = 4'd0;

    // Fill with ready low; fifth strobe overflows
    ready = 1'b0;
    step_n(2);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(i + 1);
      strobe(1'b1, i + 1, 1'b0, K_NONE);
      check("fill_count", int'(queue_count), (i < 4) ? i + 1 : 4);
      check("fill_ovf", int'(overflow), (i == 4) ? 1 : 0);
    end
    step();
    check("fill_ovf_pulse", int'(overflow), 0);
    check("fill_hold", int'(queue_count), 4);
    ready = 1'b1;
    drain(200);
    check("fill_empty", int'(queue_count), 0);

    // Same-cycle arrivals with two free, then one free, then ignored and full drops
    ready = 1'b0;
    step_n(2);
    sb.push_back(K_SOFT);
    sb.push_back(K_HOLD);
    strobe(1'b1, K_SOFT, 1'b1, K_HOLD);
    check("dual_count", int'(queue_count), 2);
    check("dual_ovf", int'(overflow), 0);
    sb.push_back(K_LEFT);
    strobe(1'b1, K_LEFT, 1'b0, K_NONE);
    check("single_count", int'(queue_count), 3);
    sb.push_back(K_RIGHT);
    strobe(1'b1, K_RIGHT, 1'b1, K_ROT);
    check("oneslot_count", int'(queue_count), 4);
    check("oneslot_ovf", int'(overflow), 1);
    strobe(1'b1, K_GRAV, 1'b1, K_NONE);
    check("ignored_ovf", int'(overflow), 0);
    check("ignored_count", int'(queue_count), 4);
    strobe(1'b0, K_NONE, 1'b1, K_LEFT);
    check("full_uart_ovf", int'(overflow), 1);
    check("full_uart_count", int'(queue_count), 4);
    ready = 1'b1;
    drain(200);

    // Pause: queue keeps filling, nothing issues, pending gravity goes first on release
    ready = 1'b0;
    step_n(20);
    pause = 1'b1;
    step();
    sb.push_back(K_LEFT);
    sb.push_back(K_HOLD);
    strobe(1'b1, K_LEFT, 1'b0, K_NONE);
    strobe(1'b0, K_NONE, 1'b1, K_HOLD);
    ready = 1'b1;
    p0 = pulses;
    step_n(40);
    check("pause_no_issue", pulses - p0, 0);
    check("pause_count", int'(queue_count), 2);
    pause = 1'b0;
    p1 = pulses;
    for (int i = 0; i < 20 && pulses == p1; i++) step();
    check("pause_first_grav", last_ctrl, K_GRAV);
    drain(200);

    // Reset in WAIT with three queued
    reset_n = 1'b0;
    step();
    check("rst2_count", int'(queue_count), 0);
    check("rst2_busy", int'(busy), 0);
    reset_n = 1'b1;
    ready = 1'b0;
    step();
    sb.push_back(K_LEFT);
    strobe(1'b1, K_LEFT, 1'b0, K_NONE);
    strobe(1'b1, K_RIGHT, 1'b0, K_NONE);
    strobe(1'b1, K_ROT, 1'b0, K_NONE);
    strobe(1'b1, K_SOFT, 1'b0, K_NONE);
    check("rwait_fill", int'(queue_count), 4);
    ready = 1'b1;
    step();
    check("rwait_issue_busy", int'(busy), 1);
    ready = 1'b0;
    step();
    check("rwait_ctl", int'(control), K_LEFT);
    step_n(2);
    check("rwait_busy", int'(busy), 1);
    check("rwait_count", int'(queue_count), 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_control", int'(control), 0);
    check("async_busy", int'(busy), 0);
    check("async_ovf", int'(overflow), 0);
    check("async_count", int'(queue_count), 0);
    step_n(3);
    reset_n = 1'b1;
    ready = 1'b1;
    p0 = pulses;
    step_n(12);
    check("post_rst_pulses", pulses - p0, 0);
    check("post_rst_count", int'(queue_count), 0);
    check("post_rst_busy", int'(busy), 0);
    check("sb_final", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
